// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: PC, instruction-memory address and IF/ID register.
// Halt FSM freezes the stage until reset; saturating stall counter for debug.
module fetch_ifid_stage #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 16,
    parameter int                 PC_INC   = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = '0,
    parameter int                 CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_seq;

    assign pc_seq    = pc + ADDR_W'(PC_INC);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ifid_instr <= NOP;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    // Counts every stalled RUN cycle, even when a redirect wins
                    if (!pc_write && stall_cnt != {CNT_W{1'b1}})
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    if (halt) begin
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                        halted     <= 1'b1;
                        state      <= HALTED;
                    end else if (branch_taken) begin
                        pc         <= branch_target;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                    end else begin
                        if (pc_write)
                            pc <= pc_seq;
                        if (ifid_write) begin
                            ifid_instr <= imem_rdata;
                            ifid_pc    <= pc_seq;
                            ifid_valid <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Randomized bench for fetch_ifid_stage against a behavioural fetch model.
// Directed reset, stall, branch, halt, wrap and saturation cases included.
module tb_fetch_ifid_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        halt;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [7:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_valid;
    logic        m_halted;
    int          m_cnt;

    fetch_ifid_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_instr  = 16'h0000;
        m_ipc    = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   32'(imem_addr),  32'(m_pc));
        chk({tag, ".instr"},  32'(ifid_instr), 32'(m_instr));
        chk({tag, ".valid"},  32'(ifid_valid), 32'(m_valid));
        if (m_valid)
            chk({tag, ".ipc"}, 32'(ifid_pc), 32'(m_ipc));
        chk({tag, ".halted"}, 32'(halted),     32'(m_halted));
        chk({tag, ".cnt"},    32'(stall_cnt),  32'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge
    task automatic step(input string tag, input logic pw, input logic iw,
                        input logic h, input logic br,
                        input logic [15:0] tgt, input logic [15:0] rd);
        pc_write      = pw;
        ifid_write    = iw;
        halt          = h;
        branch_taken  = br;
        branch_target = tgt;
        imem_rdata    = rd;
        if (!m_halted) begin
            if (!pw && m_cnt < 255)
                m_cnt++;
            if (h) begin
                m_instr  = 16'h0000;
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else if (br) begin
                m_pc    = tgt;
                m_instr = 16'h0000;
                m_valid = 1'b0;
            end else begin
                if (iw) begin
                    m_instr = rd;
                    m_ipc   = m_pc + 16'd2;
                    m_valid = 1'b1;
                end
                if (pw)
                    m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_step(input string tag, input bit allow_halt);
        logic        pw;
        logic        iw;
        logic        h;
        logic        br;
        logic [15:0] tgt;
        pw  = ($urandom_range(0, 3) != 0);
        iw  = ($urandom_range(0, 3) != 0);
        br  = ($urandom_range(0, 7) == 0);
        h   = allow_halt && ($urandom_range(0, 15) == 0);
        tgt = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 7) == 0)
            tgt = 16'hFFFC;
        step(tag, pw, iw, h, br, tgt, 16'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        halt          = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_rdata    = 16'h0000;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // T1: advance to pc=0x40, then reset mid-run without a clock edge
        for (int i = 0; i < 32; i++)
            step("t1_run", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'($urandom));
        chk("t1_pc40", 32'(imem_addr), 32'h40);
        do_reset();
        chk("t1_pc0", 32'(imem_addr), 32'h0);
        step("t1_a", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("t1_pc2", 32'(imem_addr), 32'h2);
        step("t1_b", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("t1_pc4", 32'(imem_addr), 32'h4);

        // T2: sequential fetch from 0
        do_reset();
        step("t2", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'hA123);
        chk("t2_instr", 32'(ifid_instr), 32'hA123);
        chk("t2_ipc", 32'(ifid_pc), 32'h2);
        chk("t2_valid", 32'(ifid_valid), 32'h1);
        chk("t2_pc", 32'(imem_addr), 32'h2);

        // T3: three-cycle stall at pc=6
        step("t3_a", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1111);
        step("t3_b", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h2222);
        for (int i = 0; i < 3; i++)
            step("t3_stall", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'($urandom));
        chk("t3_pc", 32'(imem_addr), 32'h6);
        chk("t3_instr", 32'(ifid_instr), 32'h2222);
        chk("t3_ipc", 32'(ifid_pc), 32'h6);
        chk("t3_cnt", 32'(stall_cnt), 32'd3);

        // T4: branch beats stall, still counted
        step("t4", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h5555);
        chk("t4_pc", 32'(imem_addr), 32'h0100);
        chk("t4_valid", 32'(ifid_valid), 32'h0);
        chk("t4_cnt", 32'(stall_cnt), 32'd4);

        // Random run without halt
        for (int i = 0; i < 400; i++)
            rand_step("rand", 1'b0);

        // T5: halt overrides branch; everything frozen afterwards
        step("t5", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
        chk("t5_halted", 32'(halted), 32'h1);
        chk("t5_valid", 32'(ifid_valid), 32'h0);
        for (int i = 0; i < 20; i++)
            rand_step("t5_frozen", 1'b1);

        // Random run with occasional halts and resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 150; i++)
                rand_step("rand_h", 1'b1);
        end

        // T6: pc wrap and stall counter saturation
        do_reset();
        step("t6_br", 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0);
        step("t6_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h7777);
        chk("t6_pc0", 32'(imem_addr), 32'h0);
        chk("t6_ipc", 32'(ifid_pc), 32'h0);
        for (int i = 0; i < 300; i++)
            step("t6_sat", 1'b0, 1'($urandom), 1'b0, 1'b0, 16'h0, 16'($urandom));
        chk("t6_cnt", 32'(stall_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
